// File: rtl/bsg_tx_gen2.sv
// Register-programmed serializer: a TX FIFO feeds an MSB-first shifter that
// emits LANES bits per bit period, paced by a CLKDIV-based divider.
module bsg_tx_gen2 #(
    parameter int DATA_W   = 8,
    parameter int LANES    = 1,
    parameter int DEPTH    = 4,
    parameter int DIV_W    = 8,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic              SYS_CLK,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic              bus_write,
    input  logic [1:0]        bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              bus_ready,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    output logic [LANES-1:0]  OUT,
    output logic              irq
);
    localparam int GROUPS = DATA_W / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [LANES-1:0] IDLE_OUT = {LANES{IDLE_LVL}};
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;
    state_t state;

    logic              txen;
    logic              intmsk;
    logic              intflag;
    logic [DIV_W-1:0]  clkdiv;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    logic [DATA_W-1:0] shreg;
    logic [GRP_W-1:0]  grp;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_cur;

    logic              tick;
    logic              last_tick;
    logic              pop;
    logic              push;
    logic              accept;
    logic              ctrl_wr;
    logic              flush;
    logic              set_flag;
    logic [DATA_W-1:0] rd_mux;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign tick      = (state == S_SHIFT) && (div_cnt == div_cur);
    assign last_tick = tick && (grp == LAST_GRP);
    assign pop       = !empty && ((state == S_LOAD) || (last_tick && txen));
    assign set_flag  = last_tick && empty;

    // A pop in the same cycle frees the slot, so a full-FIFO push still lands.
    assign bus_ready = !(bus_write && (bus_addr == 2'd1) && full && !pop);
    assign accept    = bus_valid && bus_ready;
    assign push      = accept && bus_write && (bus_addr == 2'd1);
    assign ctrl_wr   = accept && bus_write && (bus_addr == 2'd0);
    assign flush     = ctrl_wr && bus_wdata[4];
    assign irq       = intflag && intmsk;

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            2'd0:    rd_mux[3:0] = {state != S_IDLE, intflag, intmsk, txen};
            2'd2:    rd_mux = DATA_W'(clkdiv);
            2'd3:    rd_mux[CNT_W+1:0] = {empty, full, count};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (push) mem[wr_ptr] <= bus_wdata;
    end

    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            txen       <= 1'b0;
            intmsk     <= 1'b0;
            intflag    <= 1'b0;
            clkdiv     <= '0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            bus_rvalid <= accept && !bus_write;
            if (accept && !bus_write) bus_rdata <= rd_mux;
            if (ctrl_wr) begin
                txen   <= bus_wdata[0];
                intmsk <= bus_wdata[1];
            end
            if (set_flag)                    intflag <= 1'b1;
            else if (ctrl_wr && bus_wdata[2]) intflag <= 1'b0;
            if (accept && bus_write && (bus_addr == 2'd2)) clkdiv <= DIV_W'(bus_wdata);
        end
    end

    // div_cur latches CLKDIV only at group boundaries so a rewrite never
    // stretches or truncates the group currently on OUT.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            OUT     <= IDLE_OUT;
            shreg   <= '0;
            grp     <= '0;
            div_cnt <= '0;
            div_cur <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (txen && !empty) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (empty) begin
                        state <= S_IDLE;
                    end else begin
                        OUT     <= head[DATA_W-1 -: LANES];
                        shreg   <= head << LANES;
                        grp     <= '0;
                        div_cnt <= '0;
                        div_cur <= clkdiv;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        div_cur <= clkdiv;
                        if (!last_tick) begin
                            OUT   <= shreg[DATA_W-1 -: LANES];
                            shreg <= shreg << LANES;
                            grp   <= grp + 1'b1;
                        end else if (pop) begin
                            OUT   <= head[DATA_W-1 -: LANES];
                            shreg <= head << LANES;
                            grp   <= '0;
                        end else begin
                            OUT   <= IDLE_OUT;
                            grp   <= '0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
